uart_frame_tx: RTL and testbench
================================

// Module: uart_frame_tx
// PURPOSE
//  Serialises one byte per request into an asynchronous UART frame on uart_txd:
//    start bit, 8 data bits LSB first, one parity bit, then STOP_BITS stop bits.
//  It is the transmitting end for the parity-checking UART receiver; the board
//  top wires its received byte and valid strobe back into this block as an echo.
//  The bit period defaults from parameters and can be reprogrammed at run time.
// PARAMETERS
//  CLK_FREQ   25_000_000  system clock frequency in Hz
//  BAUD_RATE  115_200     default line rate; reset period = CLK_FREQ/BAUD_RATE (217)
//  STOP_BITS  1           number of stop bits, legal values 1 or 2
// PORTS
//  clk              in   1   system clock; everything is on its rising edge
//  rst_n            in   1   synchronous reset, active low
//  wr_bit_period_i  in   1   strobe: load bit_period_i into the period register
//  bit_period_i     in   32  bit period in clk cycles; values below 2 clamp to 2
//  parity_type_i    in   1   0 = even parity, 1 = odd; sampled when a frame is accepted
//  uart_tx_en       in   1   transmit request; accepted only when uart_tx_busy = 0
//  uart_tx_data     in   8   byte to send; sampled when a frame is accepted
//  uart_txd         out  1   serial line; idles high
//  uart_tx_busy     out  1   high from the cycle after acceptance until the last stop bit ends
// BEHAVIOUR
//  Reset (rst_n = 0 at a clock edge):
//    uart_txd = 1, uart_tx_busy = 0, FSM = IDLE.
//    Period register and active period = CLK_FREQ/BAUD_RATE.
//    Reset in the middle of a frame aborts it; no partial bits follow.
//  Acceptance:
//    uart_tx_en = 1 and busy = 0 at edge N -> data, parity type and period latched.
//    At edge N+1: busy = 1, uart_txd = 0 (start bit).
//    uart_tx_en while busy = 1 is ignored, with no queueing.
//  FSM: IDLE -> START -> DATA(x8) -> PARITY -> STOP(xSTOP_BITS) -> IDLE.
//    Each bit holds for exactly P cycles, where P is the period latched at acceptance.
//    A bit counter of 3 bits tracks data bits.
//    A 32-bit down-counter reloads to P-1 and advances the FSM at zero.
//  Parity bit = ^data when parity_type_i = 0; ~(^data) when parity_type_i = 1.
//  Frame length = (10 + STOP_BITS) * P cycles from the first start-bit cycle.
//  End of frame: busy drops at the edge that ends the last stop bit; uart_txd stays 1.
//    A request in that same cycle (busy = 0) is accepted.
//    Back-to-back frames therefore have zero idle gap.
//  Period writes:
//    wr_bit_period_i updates the period register in any state.
//    The frame in flight keeps its latched P; the new value applies from the next acceptance.
//    wr_bit_period_i and an acceptance in the same cycle: the new value is used.
//  uart_txd is a registered output with no combinational path from any input.
// STRUCTURE
//  uart_pkg (shared with the receiver):
//    tx_state_t enum {IDLE, START, DATA, PARITY, STOP}
//    PARITY_EVEN = 1'b0, PARITY_ODD = 1'b1
//    function calc_parity(data, type)
//  Sub-module uart_bit_timer:
//    loadable 32-bit down-counter with load, period and tick outputs.
//    The receiver reuses it.
// TESTING
//  Defaults, odd parity, send 0xA5:
//    txd = 0, 1,0,1,0,0,1,0,1, parity 1, stop 1; each bit 217 clocks.
//    busy high for exactly 2387 cycles.
//  Even parity, 0x00 then 0xFF back-to-back (uart_tx_en held high):
//    parity bits 0 then 0; second start bit begins the cycle after the first stop bit.
//  Program period 4 mid-frame:
//    current frame stays at 217 clocks per bit; the next frame uses 4 (44-cycle frame).
//    Writing period 0 gives 2-cycle bits.
//  Pulse uart_tx_en with 0x3C while busy:
//    request ignored; only the original byte appears on the line; busy timing unchanged.
//  rst_n low for one cycle during data bit 3:
//    next edge txd = 1 and busy = 0; period back to 217.
//    A subsequent 0x55 transmits correctly.
//  STOP_BITS = 2 build, send 0x81, odd parity:
//    parity bit 1; line high for 2*P cycles before busy falls.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types, parity constants and helpers for the transmitter and receiver
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD = 1'b1;
  localparam logic [31:0] MIN_PERIOD = 32'd2;
  function automatic logic calc_parity(input logic [7:0] data, input logic ptype);
    return (ptype == PARITY_ODD) ? ~(^data) : ^data;
  endfunction
  // Periods below two cycles cannot be timed by the reloading down-counter.
  function automatic logic [31:0] clamp_period(input logic [31:0] p);
    return (p < MIN_PERIOD) ? MIN_PERIOD : p;
  endfunction
endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: loadable 32-bit down-counter that ticks once per bit period
//   clk, rst_n : clock, synchronous active-low reset
//   load       : restart the count from period-1
//   period     : bit period in clk cycles (>= 2), also used on every auto-reload
//   tick       : high in the last cycle of each period
module uart_bit_timer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] period,
  output logic        tick
);
  logic [31:0] cnt;
  assign tick = cnt == '0;
  always_ff @(posedge clk)
    if (!rst_n) cnt <= '0;
    else cnt <= (load || tick) ? period - 32'd1 : cnt - 32'd1;
endmodule

// File: rtl/uart_frame_tx.sv
// uart_frame_tx: serialises a byte into start, 8 data (LSB first), parity and stop bits
//   clk, rst_n      : clock, synchronous active-low reset
//   wr_bit_period_i : load bit_period_i (clamped to >= 2) into the period register
//   bit_period_i    : bit period in clk cycles
//   parity_type_i   : 0 even, 1 odd; latched at acceptance
//   uart_tx_en      : transmit request
//   uart_tx_data    : byte to send; latched at acceptance
//   uart_txd        : registered serial line, idles high
//   uart_tx_busy    : high while a frame is on the line
module uart_frame_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 25_000_000,
  parameter int BAUD_RATE = 115_200,
  parameter int STOP_BITS = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_bit_period_i,
  input  logic [31:0] bit_period_i,
  input  logic        parity_type_i,
  input  logic        uart_tx_en,
  input  logic [7:0]  uart_tx_data,
  output logic        uart_txd,
  output logic        uart_tx_busy
);
  localparam logic [31:0] DEF_PERIOD = 32'(CLK_FREQ / BAUD_RATE);
  tx_state_t state, state_n;
  logic [31:0] period_reg, p_lat, p_new;
  logic [7:0] sh;
  logic [2:0] bit_cnt;
  logic stop_cnt, par, txd_n, tick, accept, last_stop, last_bit;
  assign uart_tx_busy = state != IDLE;
  assign last_bit = bit_cnt == 3'd7;
  assign last_stop = stop_cnt == 1'(STOP_BITS - 1);
  // A write in the accepting cycle takes effect for that frame.
  assign p_new = wr_bit_period_i ? clamp_period(bit_period_i) : period_reg;
  // The edge that ends the last stop bit may start the next frame, giving zero idle gap.
  assign accept = uart_tx_en && (state == IDLE || (state == STOP && tick && last_stop));
  uart_bit_timer u_timer (
    .clk(clk),
    .rst_n(rst_n),
    .load(accept),
    .period(accept ? p_new : p_lat),
    .tick(tick)
  );
  always_comb begin
    state_n = state;
    txd_n = uart_txd;
    case (state)
      START: if (tick) begin
        state_n = DATA;
        txd_n = sh[0];
      end
      DATA: if (tick) begin
        state_n = last_bit ? PARITY : DATA;
        txd_n = last_bit ? par : sh[1];
      end
      PARITY: if (tick) begin
        state_n = STOP;
        txd_n = 1'b1;
      end
      STOP: if (tick && last_stop) state_n = IDLE;
      default: ;
    endcase
    if (accept) begin
      state_n = START;
      txd_n = 1'b0;
    end
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      uart_txd <= 1'b1;
      period_reg <= DEF_PERIOD;
      p_lat <= DEF_PERIOD;
      sh <= '0;
      par <= 1'b0;
      bit_cnt <= '0;
      stop_cnt <= 1'b0;
    end else begin
      state <= state_n;
      uart_txd <= txd_n;
      if (wr_bit_period_i) period_reg <= clamp_period(bit_period_i);
      if (accept) begin
        p_lat <= p_new;
        sh <= uart_tx_data;
        par <= calc_parity(uart_tx_data, parity_type_i);
        bit_cnt <= '0;
        stop_cnt <= 1'b0;
      end else if (tick) begin
        if (state == DATA) begin
          sh <= sh >> 1;
          bit_cnt <= bit_cnt + 3'd1;
        end
        if (state == STOP) stop_cnt <= stop_cnt + 1'b1;
      end
    end
endmodule

// File: tb/tb_uart_frame_tx.sv
// tb_uart_frame_tx: scoreboard bench for one- and two-stop-bit transmitters driven by shared stimulus
module tb_uart_frame_tx;
  typedef struct {
    int start;
    int p;
    logic [7:0] d;
    logic par;
  } frame_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic wr = 1'b0;
  logic [31:0] bp = '0;
  logic par_type = 1'b0;
  logic en = 1'b0;
  logic [7:0] data = '0;
  logic txd1, busy1, txd2, busy2;
  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  int regp = 217;
  int free1 = 0;
  int free2 = 0;
  frame_t q1[$];
  frame_t q2[$];
  always #5 clk = ~clk;
  uart_frame_tx #(.STOP_BITS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .wr_bit_period_i(wr), .bit_period_i(bp),
    .parity_type_i(par_type), .uart_tx_en(en), .uart_tx_data(data),
    .uart_txd(txd1), .uart_tx_busy(busy1)
  );
  uart_frame_tx #(.STOP_BITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .wr_bit_period_i(wr), .bit_period_i(bp),
    .parity_type_i(par_type), .uart_tx_en(en), .uart_tx_data(data),
    .uart_txd(txd2), .uart_tx_busy(busy2)
  );
  function automatic int clampi(input int p);
    return p < 2 ? 2 : p;
  endfunction
  function automatic logic ref_parity(input logic [7:0] d, input logic odd);
    return logic'($countones(d) % 2) ^ odd;
  endfunction
  // Reference model: a frame accepted at edge e occupies cycles e .. e+(10+S)*P-1;
  // the next request is honoured from edge e+(10+S)*P onwards.
  always @(posedge clk) begin
    int pn;
    cyc++;
    if (!rst_n) begin
      q1.delete();
      q2.delete();
      free1 = 0;
      free2 = 0;
      regp = 217;
    end else begin
      pn = wr ? clampi(int'(bp)) : regp;
      if (en && cyc >= free1) begin
        q1.push_back('{cyc, pn, data, ref_parity(data, par_type)});
        free1 = cyc + 11 * pn;
      end
      if (en && cyc >= free2) begin
        q2.push_back('{cyc, pn, data, ref_parity(data, par_type)});
        free2 = cyc + 12 * pn;
      end
      if (wr) regp = clampi(int'(bp));
    end
  end
  task automatic check(input int id, input logic txd, input logic busy);
    frame_t f;
    logic et, eb, have;
    int k, len;
    len = id == 1 ? 11 : 12;
    have = 1'b0;
    if (id == 1) begin
      while (q1.size() > 0 && q1[0].start + len * q1[0].p <= cyc) q1.delete(0);
      if (q1.size() > 0) begin f = q1[0]; have = 1'b1; end
    end else begin
      while (q2.size() > 0 && q2[0].start + len * q2[0].p <= cyc) q2.delete(0);
      if (q2.size() > 0) begin f = q2[0]; have = 1'b1; end
    end
    et = 1'b1;
    eb = 1'b0;
    if (have) begin
      k = (cyc - f.start) / f.p;
      eb = 1'b1;
      et = k == 0 ? 1'b0 : k <= 8 ? f.d[k-1] : k == 9 ? f.par : 1'b1;
    end
    vectors++;
    if (txd !== et || busy !== eb) begin
      miscompares++;
      $display("FAIL line dut%0d cycle %0d: txd=%b busy=%b, required txd=%b busy=%b", id, cyc, txd, busy, et, eb);
    end
  endtask
  always @(negedge clk)
    if (cyc > 0) begin
      check(1, txd1, busy1);
      check(2, txd2, busy2);
    end
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] d, input logic odd);
    en = 1'b1;
    data = d;
    par_type = odd;
    step(1);
    en = 1'b0;
  endtask
  task automatic setp(input int p);
    wr = 1'b1;
    bp = 32'(p);
    step(1);
    wr = 1'b0;
  endtask
  initial begin
    step(3);
    rst_n = 1'b1;
    step(2);
    send(8'hA5, 1'b1);
    step(12 * 217 + 10);
    par_type = 1'b0;
    en = 1'b1;
    data = 8'h00;
    step(1);
    data = 8'hFF;
    step(11 * 217);
    en = 1'b0;
    step(11 * 217 + 10);
    send(8'h6E, 1'b1);
    step(300);
    setp(4);
    step(12 * 217);
    send(8'h3B, 1'b0);
    step(60);
    setp(0);
    send(8'hD2, 1'b1);
    step(40);
    setp(9);
    send(8'hC3, 1'b0);
    step(20);
    send(8'h3C, 1'b1);
    step(130);
    send(8'h96, 1'b1);
    step(38);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(3);
    send(8'h55, 1'b0);
    step(12 * 217 + 10);
    send(8'h81, 1'b1);
    step(12 * 217 + 10);
    for (int i = 0; i < 4000; i++) begin
      en = $urandom_range(0, 3) == 0;
      data = 8'($urandom);
      par_type = 1'($urandom);
      wr = $urandom_range(0, 24) == 0;
      bp = 32'($urandom_range(0, 12));
      step(1);
    end
    en = 1'b0;
    wr = 1'b0;
    step(12 * 217 + 10);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
